// File: rtl/tsmac_nto128_rx_pkg.sv
// Shared definitions for the N-to-128 receive packer: FSM encoding, line geometry
// and the field layout of the per-packet status word.
package tsmac_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RCV     = 2'd1,
    ST_DISCARD = 2'd2
  } rxState_t;

  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = 8 * LINE_BYTES;

  localparam int STAT_W         = 96;
  localparam int STAT_VALID_POS = 95;
  localparam int STAT_LEN_LSB   = 80;
  localparam int STAT_LEN_W     = 15;
  localparam int STAT_ID_LSB    = 64;
  localparam int STAT_ID_W      = 16;
  localparam int STAT_TIME_LSB  = 0;
  localparam int STAT_TIME_W    = 64;

  localparam logic [STAT_LEN_W-1:0] LEN_SAT = '1;
  localparam int DROP_W = 16;

  function automatic logic [STAT_W-1:0] packStat(
    input logic                   valid,
    input logic [STAT_LEN_W-1:0]  len,
    input logic [STAT_ID_W-1:0]   id,
    input logic [STAT_TIME_W-1:0] sopTime
  );
    logic [STAT_W-1:0] stat;
    stat = '0;
    stat[STAT_VALID_POS]                  = valid;
    stat[STAT_LEN_LSB  +: STAT_LEN_W]     = len;
    stat[STAT_ID_LSB   +: STAT_ID_W]      = id;
    stat[STAT_TIME_LSB +: STAT_TIME_W]    = sopTime;
    return stat;
  endfunction

endpackage

// File: rtl/tsmac_nto128_rx_if.sv
// MAC-side stream plus packet-buffer-side line/status bus of the receive packer.
// master = MAC/buffer side driving the stream, slave = the packer itself.
interface tsmac_nto128_rx_if #(
  parameter int IN_W = 1
);

  logic                              rx_tvalid;
  logic                              rx_tlast;
  logic [8*IN_W-1:0]                 rx_tdata;
  logic [IN_W-1:0]                   rx_tkeep;
  logic                              rx_tuser;

  logic                              pkt_rcv_ready;
  logic                              pkt_wr;
  logic [tsmac_rx_pkg::LINE_W-1:0]   pkt_data;
  logic                              pkt_stat_wr;
  logic [tsmac_rx_pkg::STAT_W-1:0]   pkt_stat;

  modport master (
    output rx_tvalid, rx_tlast, rx_tdata, rx_tkeep, rx_tuser, pkt_rcv_ready,
    input  pkt_wr, pkt_data, pkt_stat_wr, pkt_stat
  );

  modport slave (
    input  rx_tvalid, rx_tlast, rx_tdata, rx_tkeep, rx_tuser, pkt_rcv_ready,
    output pkt_wr, pkt_data, pkt_stat_wr, pkt_stat
  );

endinterface

// File: rtl/tsmac_nto128_rx_lane_packer.sv
// Drops the keep-qualified bytes of one beat into a 16-byte line at a byte offset.
// Line byte 0 sits in the top bits; beat lane 0 is the earliest byte.
module tsmac_rx_lane_packer
  import tsmac_rx_pkg::*;
#(
  parameter int IN_W = 1
) (
  input  logic [LINE_W-1:0] i_line,
  input  logic [3:0]        i_offset,
  input  logic [8*IN_W-1:0] i_data,
  input  logic [IN_W-1:0]   i_keep,
  output logic [LINE_W-1:0] o_line,
  output logic [3:0]        o_count
);

  // Keep is contiguous from lane 0, so lane i always lands at offset+i.
  always_comb begin
    o_line  = i_line;
    o_count = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (i_keep[i]) begin
        o_line[{4'd15 - (i_offset + 4'(i)), 3'b000} +: 8] = i_data[8*i +: 8];
        o_count = o_count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/tsmac_nto128_rx.sv
// Receive packer: gathers IN_W-byte MAC beats into 128-bit buffer lines, tags each
// packet with length/id/SOP time, and drops whole packets the buffer cannot take.
module tsmac_nto128_rx
  import tsmac_rx_pkg::*;
#(
  parameter int IN_W    = 1,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic                 port_rx_clk,
  input  logic                 port_rx_rst_n,
  tsmac_nto128_rx_if.slave     rx_bus,
  input  logic [63:0]          sys_port_time,
  output logic                 rx_overflow,
  output logic [DROP_W-1:0]    rx_drop_cnt
);

  localparam logic [STAT_LEN_W-1:0] MIN_L = 15'(MIN_LEN);
  localparam logic [STAT_LEN_W-1:0] MAX_L = 15'(MAX_LEN);

  rxState_t                r_state;
  logic                    r_inPkt;
  logic [LINE_W-1:0]       r_line;
  logic [3:0]              r_lineOff;
  logic [LINE_W-1:0]       r_pktData;
  logic                    r_pktWr;
  logic                    r_pktStatWr;
  logic                    r_pktValid;
  logic [STAT_LEN_W-1:0]   r_pktLen;
  logic [STAT_ID_W-1:0]    r_pktId;
  logic [STAT_TIME_W-1:0]  r_sopTime;
  logic [DROP_W-1:0]       r_dropCnt;

  logic                    w_sop;
  logic                    w_lastBeat;
  logic                    w_accept;
  logic [LINE_W-1:0]       w_baseLine;
  logic [3:0]              w_baseOff;
  logic [LINE_W-1:0]       w_mergedLine;
  logic [3:0]              w_beatCnt;
  logic [4:0]              w_endOff;
  logic [STAT_LEN_W-1:0]   w_lenBase;
  logic [STAT_LEN_W:0]     w_lenSum;
  logic [STAT_LEN_W-1:0]   w_newLen;
  logic                    w_newValid;

  assign w_sop      = rx_bus.rx_tvalid & ~r_inPkt;
  assign w_lastBeat = rx_bus.rx_tvalid & rx_bus.rx_tlast;
  assign w_accept   = rx_bus.rx_tvalid &
                      ((r_state == ST_RCV) | (w_sop & rx_bus.pkt_rcv_ready));

  // A new packet always starts from an empty line at offset 0.
  assign w_baseLine = w_sop ? '0 : r_line;
  assign w_baseOff  = w_sop ? 4'd0 : r_lineOff;

  tsmac_rx_lane_packer #(
    .IN_W (IN_W)
  ) u_packer (
    .i_line   (w_baseLine),
    .i_offset (w_baseOff),
    .i_data   (rx_bus.rx_tdata),
    .i_keep   (rx_bus.rx_tkeep),
    .o_line   (w_mergedLine),
    .o_count  (w_beatCnt)
  );

  assign w_endOff   = {1'b0, w_baseOff} + {1'b0, w_beatCnt};
  assign w_lenBase  = w_sop ? 15'd0 : r_pktLen;
  assign w_lenSum   = {1'b0, w_lenBase} + {12'd0, w_beatCnt};
  assign w_newLen   = w_lenSum[STAT_LEN_W] ? LEN_SAT : w_lenSum[STAT_LEN_W-1:0];
  assign w_newValid = ~rx_bus.rx_tuser & (w_newLen >= MIN_L) & (w_newLen <= MAX_L);

  assign rx_overflow = w_lastBeat &
                       ((r_state == ST_DISCARD) | (w_sop & ~rx_bus.pkt_rcv_ready));

  // Status fields are only updated on accepted beats, so a back-to-back SOP in the
  // pkt_stat_wr cycle cannot disturb the word being presented.
  always_ff @(posedge port_rx_clk or negedge port_rx_rst_n) begin
    if (!port_rx_rst_n) begin
      r_state     <= ST_IDLE;
      r_inPkt     <= 1'b0;
      r_line      <= '0;
      r_lineOff   <= '0;
      r_pktData   <= '0;
      r_pktWr     <= 1'b0;
      r_pktStatWr <= 1'b0;
      r_pktValid  <= 1'b0;
      r_pktLen    <= '0;
      r_pktId     <= '0;
      r_sopTime   <= '0;
      r_dropCnt   <= '0;
    end else begin
      r_pktWr     <= 1'b0;
      r_pktStatWr <= 1'b0;

      if (r_pktStatWr) begin
        r_pktId <= r_pktId + 16'd1;
      end

      if (rx_bus.rx_tvalid) begin
        r_inPkt <= ~rx_bus.rx_tlast;
        case (r_state)
          ST_IDLE: begin
            if (!rx_bus.rx_tlast) begin
              r_state <= rx_bus.pkt_rcv_ready ? ST_RCV : ST_DISCARD;
            end
          end
          ST_RCV, ST_DISCARD: begin
            if (rx_bus.rx_tlast) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (w_accept) begin
        r_pktLen <= w_newLen;
        if (w_sop) begin
          r_sopTime <= sys_port_time;
        end
        if (w_endOff[4] | rx_bus.rx_tlast) begin
          r_pktData <= w_mergedLine;
          r_pktWr   <= 1'b1;
          r_line    <= '0;
          r_lineOff <= '0;
        end else begin
          r_line    <= w_mergedLine;
          r_lineOff <= w_endOff[3:0];
        end
        if (rx_bus.rx_tlast) begin
          r_pktStatWr <= 1'b1;
          r_pktValid  <= w_newValid;
        end
      end

      if (rx_overflow && (r_dropCnt != 16'hFFFF)) begin
        r_dropCnt <= r_dropCnt + 16'd1;
      end
    end
  end

  assign rx_bus.pkt_wr      = r_pktWr;
  assign rx_bus.pkt_data    = r_pktData;
  assign rx_bus.pkt_stat_wr = r_pktStatWr;
  assign rx_bus.pkt_stat    = packStat(r_pktValid, r_pktLen, r_pktId, r_sopTime);
  assign rx_drop_cnt        = r_dropCnt;

endmodule
